// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte/half/word load-store unit with split-access support
//
// Accepts one load or store at a time from the pipeline and turns it into one
// or two word-aligned memory beats. Misaligned accesses that cross a word
// boundary are split into two beats. Load bytes are gathered from the enabled
// lanes and then sign- or zero-extended.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/ready     request handshake (ready only while idle)
//   req_we              1 = store, 0 = load
//   req_funct3          access size/sign (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   req_addr            byte address
//   req_wdata           store data, LSB-justified
//   rsp_valid           one-cycle completion pulse
//   rsp_rdata           extended load data (0 for stores and errors)
//   rsp_err             illegal funct3
//   mem_req/mem_gnt     memory command handshake
//   mem_we              memory write enable
//   mem_addr            word-aligned memory address
//   mem_be              byte lane enables
//   mem_wdata           lane-aligned store data
//   mem_rvalid          read data return strobe
//   mem_rdata           read data (full word, all lanes)

module load_store_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ0  = 3'd1,
    WAIT0 = 3'd2,
    REQ1  = 3'd3,
    WAIT1 = 3'd4,
    RESP  = 3'd5
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  state_t      state;

  // Captured request
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic [3:0]  be1_q;       // beat-1 lane enables; zero means single beat
  logic [31:0] wdata1_q;    // beat-1 store data
  logic [31:0] lo_q;        // beat-0 read data of a split load
  logic        split;

  // Request decode
  logic        req_legal;
  logic [3:0]  size_mask;
  logic [7:0]  be_span;
  logic [63:0] wdata_span;

  // Load assembly
  logic [63:0] rd_span;
  logic [31:0] rd_raw;
  logic [31:0] rd_ext;

  assign split = |be1_q;

  // The access is laid out across an 8-byte window (two words). The low half
  // of each span is beat 0, the high half is beat 1.
  always_comb begin
    size_mask = 4'b0001;
    case (req_funct3[1:0])
      2'b01:   size_mask = 4'b0011;
      2'b10:   size_mask = 4'b1111;
      default: size_mask = 4'b0001;
    endcase

    req_legal = 1'b0;
    if (req_we) begin
      req_legal = (req_funct3 == F3_B) || (req_funct3 == F3_H) ||
                  (req_funct3 == F3_W);
    end else begin
      req_legal = (req_funct3 == F3_B)  || (req_funct3 == F3_H) ||
                  (req_funct3 == F3_W)  || (req_funct3 == F3_BU) ||
                  (req_funct3 == F3_HU);
    end

    be_span    = {4'b0000, size_mask} << req_addr[1:0];
    wdata_span = {32'h0, req_wdata} << {req_addr[1:0], 3'b000};
  end

  // Beat-0 lanes form the low bytes, beat-1 lanes the high bytes; shifting
  // the two-word window down by the offset leaves the access LSB-justified.
  always_comb begin
    if (state == WAIT1) begin
      rd_span = {mem_rdata, lo_q};
    end else begin
      rd_span = {32'h0, mem_rdata};
    end
    rd_raw = 32'(rd_span >> {off_q, 3'b000});

    case (funct3_q)
      F3_B:    rd_ext = {{24{rd_raw[7]}}, rd_raw[7:0]};
      F3_H:    rd_ext = {{16{rd_raw[15]}}, rd_raw[15:0]};
      F3_BU:   rd_ext = {24'h0, rd_raw[7:0]};
      F3_HU:   rd_ext = {16'h0, rd_raw[15:0]};
      default: rd_ext = rd_raw;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_be    <= 4'h0;
      mem_wdata <= 32'h0;
      we_q      <= 1'b0;
      funct3_q  <= 3'b000;
      off_q     <= 2'b00;
      be1_q     <= 4'h0;
      wdata1_q  <= 32'h0;
      lo_q      <= 32'h0;
    end else begin
      rsp_valid <= 1'b0;

      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            we_q      <= req_we;
            funct3_q  <= req_funct3;
            off_q     <= req_addr[1:0];
            be1_q     <= be_span[7:4];
            wdata1_q  <= wdata_span[63:32];
            if (req_legal) begin
              state     <= REQ0;
              mem_req   <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_be    <= be_span[3:0];
              mem_wdata <= req_we ? wdata_span[31:0] : 32'h0;
            end else begin
              // Illegal size code: answer immediately, never touch memory.
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= 32'h0;
              rsp_err   <= 1'b1;
            end
          end
        end

        REQ0: begin
          if (mem_gnt) begin
            if (we_q && split) begin
              // Second store beat goes out back-to-back; mem_req stays high.
              state     <= REQ1;
              mem_addr  <= mem_addr + 32'd4;
              mem_be    <= be1_q;
              mem_wdata <= wdata1_q;
            end else if (we_q) begin
              state     <= RESP;
              mem_req   <= 1'b0;
              rsp_valid <= 1'b1;
              rsp_rdata <= 32'h0;
              rsp_err   <= 1'b0;
            end else begin
              state   <= WAIT0;
              mem_req <= 1'b0;
            end
          end
        end

        WAIT0: begin
          if (mem_rvalid) begin
            if (split) begin
              state    <= REQ1;
              lo_q     <= mem_rdata;
              mem_req  <= 1'b1;
              mem_addr <= mem_addr + 32'd4;
              mem_be   <= be1_q;
            end else begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= rd_ext;
              rsp_err   <= 1'b0;
            end
          end
        end

        REQ1: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            if (we_q) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= 32'h0;
              rsp_err   <= 1'b0;
            end else begin
              state <= WAIT1;
            end
          end
        end

        WAIT1: begin
          if (mem_rvalid) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= rd_ext;
            rsp_err   <= 1'b0;
          end
        end

        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_rdata <= 32'h0;
          rsp_err   <= 1'b0;
        end

        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          mem_req   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-002 SHALL have port rst_n  input  1  reset; asynchronous assert, active-low.
REQ-003 SHALL have ports req_valid in 1, req_ready out 1: pipeline request handshake.
REQ-004 SHALL have ports req_we in 1 (1=store), req_funct3 in 3 (access size/sign), req_addr in 32 (byte address), req_wdata in 32 (store data, LSB-justified).
REQ-005 SHALL have ports rsp_valid out 1 (one-cycle completion pulse), rsp_rdata out 32 (extended load data), rsp_err out 1 (illegal funct3).
REQ-006 SHALL have ports mem_req out 1 and mem_gnt in 1: memory command handshake.
REQ-007 SHALL have ports mem_we out 1, mem_addr out 32 (word-aligned, bits[1:0]=0), mem_be out 4 (byte lane enables), mem_wdata out 32 (lane-aligned).
REQ-008 SHALL have ports mem_rvalid in 1 and mem_rdata in 32: read return, at least 1 cycle after the granting cycle.

Function
REQ-009 SHALL assert req_ready only in IDLE; a request is accepted on req_valid&&req_ready, and all req_* fields are captured.
REQ-010 SHALL decode funct3 as follows.
- Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Stores: 000 SB, 001 SH, 010 SW.
- Any other code SHALL give rsp_err=1, rsp_rdata=0 and rsp_valid the cycle after acceptance, with no memory access.
REQ-011 SHALL use FSM states IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
- IDLE→REQ0 on accept (legal funct3); IDLE→RESP on accept (illegal funct3).
- REQx→next when mem_gnt: a store goes to REQ1/RESP; a load goes to WAITx.
- WAITx→next on mem_rvalid; REQ1/WAIT1 are used only for a split access.
- RESP→IDLE unconditionally.
REQ-012 SHALL treat an access as split (two beats) when offset=addr[1:0] and size bytes n satisfy offset+n>4, e.g. LH at offset 3, LW at offset 1..3.
REQ-013 SHALL use beat-0 mem_addr = {addr[31:2],2'b00} and beat-1 mem_addr = beat-0 + 4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
REQ-014 SHALL compute beat-0 mem_be = ((1<<n)-1)<<offset truncated to 4 bits, and beat-1 mem_be = ((1<<n)-1)>>(4-offset).
REQ-015 SHALL drive beat-0 mem_wdata = wdata<<(8*offset) and beat-1 mem_wdata = wdata>>(8*(4-offset)); mem_wdata is don't-care on loads.
REQ-016 SHALL register mem_req/mem_we/mem_addr/mem_be/mem_wdata and hold them stable while mem_req=1 and mem_gnt=0.
- mem_req deasserts the cycle after grant unless the next beat is issued.
- At most one beat is outstanding.
REQ-017 SHALL assemble load bytes from enabled lanes: beat-0 lanes supply the low bytes and beat-1 lanes the high bytes.
- LB/LH extend sign from bit 7/15; LBU/LHU zero-extend; LW passes through.
REQ-018 SHALL assert rsp_valid for exactly one cycle, in RESP.
- rsp_rdata is valid during that pulse.
- rsp_rdata=0 and rsp_err=0 for stores.
REQ-019 SHALL ignore mem_rvalid in IDLE, REQx and RESP, and ignore mem_gnt outside REQx.
REQ-020 SHALL give minimum latency as follows, with mem_gnt arriving on first request and mem_rvalid 1 cycle later.
- Aligned store: acceptance cycle T, mem_req T+1, rsp_valid T+2.
- Aligned load: rsp_valid T+3.
- Split load: rsp_valid T+5.

Reset
REQ-021 SHALL, while rst_n=0, force the following immediately regardless of clk.
- FSM=IDLE.
- mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0.
- rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-022 SHALL drive req_ready=1 from the first cycle after rst_n deasserts.
REQ-023 SHALL abandon any in-flight transaction on reset without producing rsp_valid; a late mem_rvalid after reset SHALL be ignored.

Verification
REQ-024 SHALL cover an LW at 0x100 with mem_rdata=0xDEADBEEF. Required: one beat, addr 0x100, be 1111, rsp_rdata 0xDEADBEEF at T+3.
REQ-025 SHALL cover an LB at 0x103 with mem_rdata=0x80FF0000, then an LBU at 0x103. Required: be 1000; rsp_rdata 0xFFFFFF80 for LB, then 0x00000080 for LBU.
REQ-026 SHALL cover an SH at 0x0FF with wdata=0x0000ABCD. Required behaviour:
- Beat 0: addr 0x0FC, be 1000, wdata 0xCD000000.
- Beat 1: addr 0x100, be 0001, wdata 0x000000AB.
- One rsp_valid after the second grant.
REQ-027 SHALL cover an LW at 0xFFFFFFFE with beat data 0x1234XXXX then 0xXXXX5678. Required: beat-1 addr 0x00000000, rsp_rdata 0x56781234.
REQ-028 SHALL cover mem_gnt held low 3 cycles, then reset asserted mid-WAIT0 with rvalid arriving after release. Required:
- mem_* stable while the grant is pending.
- All outputs zero during reset.
- No rsp_valid.
- req_ready=1 after release.
REQ-029 SHALL cover funct3=011 accepted as a load. Required: no mem_req, rsp_valid with rsp_err=1 one cycle later.
